// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory bus between the load/store unit and memory.
//   memReq/memWe/memAddr/memBe/memWdata : request side, driven by the LSU (master)
//   memRdata/memAck                     : response side, driven by memory (slave)
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [3:0]        memBe;
    logic [31:0]       memWdata;
    logic [31:0]       memRdata;
    logic              memAck;

    modport master (
        output memReq, memWe, memAddr, memBe, memWdata,
        input  memRdata, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memBe, memWdata,
        output memRdata, memAck
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: turns control-unit load/store strobes into one word-aligned,
// byte-enabled request/ack transaction on the data-memory bus, and returns a
// sign/zero-extended load result.
//   clk, rst             : clock, asynchronous active-high reset
//   dMemRead, dMemWrite  : request levels from the control unit
//   funct3, addr         : access size/signedness and effective address
//   storeData            : rs2 value for stores
//   loadData             : extended load result (held until the next load)
//   lsuDone, accessErr   : one-cycle completion / illegal-access pulses
//   lsuBusy              : high while a transaction is in flight
//   mem                  : data-memory bus (master side)
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dMemRead,
    input  logic              dMemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       storeData,
    output logic [31:0]       loadData,
    output logic              lsuDone,
    output logic              lsuBusy,
    output logic              accessErr,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic              arm_q, arm_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        load_ok, store_ok, misaligned, bad_access;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, shifted, load_ext;

    // Legality and lane formatting of the incoming request.
    always_comb begin
        load_ok    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_ok   = funct3 inside {3'b000, 3'b001, 3'b010};
        misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        bad_access = (dMemRead && dMemWrite) || misaligned ||
                     (dMemWrite ? !store_ok : !load_ok);
        case (funct3[1:0])
            2'b00:   begin be_new = 4'b0001 << addr[1:0]; wdata_new = {4{storeData[7:0]}};  end
            2'b01:   begin be_new = 4'b0011 << addr[1:0]; wdata_new = {2{storeData[15:0]}}; end
            default: begin be_new = 4'b1111;              wdata_new = storeData;            end
        endcase
    end

    // Move the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        shifted = mem.memRdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Bus outputs are formatted at accept and held in REQ, so storeData/addr
    // need not be kept beyond the byte offset and funct3 used for extraction.
    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        req_d       = req_q;
        we_d        = we_q;
        maddr_d     = maddr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;

        if (!dMemRead && !dMemWrite) arm_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (arm_q && (dMemRead || dMemWrite)) begin
                    arm_d    = 1'b0;
                    busy_d   = 1'b1;
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    if (bad_access) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = dMemWrite;
                        maddr_d = {addr[ADDR_W-1:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                    end
                end
            end
            REQ: begin
                if (mem.memAck) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    maddr_d = '0;
                    be_d    = '0;
                    wdata_d = '0;
                    if (!we_q) load_data_d = load_ext;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            arm_q       <= 1'b1;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            req_q       <= req_d;
            we_q        <= we_d;
            maddr_q     <= maddr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
        end
    end

    assign loadData     = load_data_q;
    assign lsuDone      = done_q;
    assign lsuBusy      = busy_q;
    assign accessErr    = err_q;
    assign mem.memReq   = req_q;
    assign mem.memWe    = we_q;
    assign mem.memAddr  = maddr_q;
    assign mem.memBe    = be_q;
    assign mem.memWdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against an
// arithmetic model of the load/store rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        dMemRead, dMemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, storeData;
    logic [31:0] loadData;
    logic        lsuDone, lsuBusy, accessErr;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .dMemRead  (dMemRead),
        .dMemWrite (dMemWrite),
        .funct3    (funct3),
        .addr      (addr),
        .storeData (storeData),
        .loadData  (loadData),
        .lsuDone   (lsuDone),
        .lsuBusy   (lsuBusy),
        .accessErr (accessErr),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_ld = '0;

    typedef struct {
        int          lat;
        int          req_cycles;
        bit          err;
        bit          stable;
        bit          busy1;
        bit          busy_after;
        bit          done_after;
        bit          req_after;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_err(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (rd && wr) return 1;
        if (wr && f3 > 3'd2) return 1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be = '0;
        for (int i = 0; i < size_of(f3); i++) be[(a % 4) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % size_of(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = size_of(f3);
        int off = a % 4;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n - 1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- driver (observes, does not judge) ----------------
    task automatic drive_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                             output obs_t o);
        int k = 0;
        o.lat = -1; o.req_cycles = 0; o.err = 0; o.stable = 1; o.we = 0;
        o.maddr = '0; o.be = '0; o.wd = '0; o.ld = '0;
        dMemRead = rd; dMemWrite = wr; funct3 = f3; addr = a; storeData = sd;
        @(negedge clk);
        dMemRead = 0; dMemWrite = 0;
        funct3 = 3'($urandom); addr = $urandom; storeData = $urandom;
        o.busy1 = lsuBusy;
        for (int cyc = 1; cyc <= 40 && o.lat < 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            bus.memAck = 1'b0;
            bus.memRdata = $urandom;
            if (lsuDone) begin
                o.lat = cyc; o.err = accessErr; o.ld = loadData;
            end
            if (bus.memReq) begin
                if (o.req_cycles == 0) begin
                    o.maddr = bus.memAddr; o.be = bus.memBe; o.wd = bus.memWdata; o.we = bus.memWe;
                end else if ({o.maddr, o.be, o.wd, o.we} !== {bus.memAddr, bus.memBe, bus.memWdata, bus.memWe}) begin
                    o.stable = 0;
                end
                o.req_cycles++;
                if (k == waits) begin
                    bus.memAck = 1'b1; bus.memRdata = rdata;
                end
                k++;
            end
        end
        @(negedge clk);
        bus.memAck = 1'b0;
        o.busy_after = lsuBusy; o.done_after = lsuDone; o.req_after = bus.memReq;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        vectors++;
        if ({loadData, lsuDone, lsuBusy, accessErr, bus.memReq, bus.memWe, bus.memAddr, bus.memBe, bus.memWdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ld=%h done=%b busy=%b err=%b req=%b we=%b addr=%h be=%b wd=%h, want all 0",
                     loadData, lsuDone, lsuBusy, accessErr, bus.memReq, bus.memWe, bus.memAddr, bus.memBe, bus.memWdata);
        end
    endtask

    task automatic test_lw_waits;
        obs_t o;
        drive_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, o);
        exp_ld = 32'hDEADBEEF;
        vectors++;
        if ({o.maddr, o.be, o.we} !== {32'h100, 4'b1111, 1'b0}) begin
            miscompares++; $display("FAIL lw_bus: got addr=%h be=%b we=%b, want 100 1111 0", o.maddr, o.be, o.we);
        end
        vectors++;
        if (o.lat != 4 || o.req_cycles != 3 || !o.stable) begin
            miscompares++; $display("FAIL lw_timing: got lat=%0d req_cycles=%0d stable=%0b, want 4 3 1", o.lat, o.req_cycles, o.stable);
        end
        vectors++;
        if (o.ld !== exp_ld || o.err !== 1'b0) begin
            miscompares++; $display("FAIL lw_data: got ld=%h err=%b, want %h 0", o.ld, o.err, exp_ld);
        end
        vectors++;
        if (o.busy1 !== 1'b1 || o.busy_after !== 1'b0 || o.done_after !== 1'b0) begin
            miscompares++; $display("FAIL lw_busy: got busy1=%b busy_after=%b done_after=%b, want 1 0 0", o.busy1, o.busy_after, o.done_after);
        end
    endtask

    task automatic test_lb_lbu;
        obs_t o;
        drive_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, o);
        vectors++;
        if (o.be !== 4'b1000 || o.ld !== 32'hFFFFFF80 || o.lat != 2) begin
            miscompares++; $display("FAIL lb: got be=%b ld=%h lat=%0d, want 1000 ffffff80 2", o.be, o.ld, o.lat);
        end
        drive_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, o);
        exp_ld = 32'h00000080;
        vectors++;
        if (o.be !== 4'b1000 || o.ld !== exp_ld || o.lat != 2) begin
            miscompares++; $display("FAIL lbu: got be=%b ld=%h lat=%0d, want 1000 00000080 2", o.be, o.ld, o.lat);
        end
    endtask

    task automatic test_sh;
        obs_t o;
        drive_txn(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 32'h11111111, 1, o);
        vectors++;
        if ({o.maddr, o.be, o.wd, o.we} !== {32'h20, 4'b1100, 32'hABCDABCD, 1'b1}) begin
            miscompares++; $display("FAIL sh_bus: got addr=%h be=%b wd=%h we=%b, want 20 1100 abcdabcd 1", o.maddr, o.be, o.wd, o.we);
        end
        vectors++;
        if (o.ld !== exp_ld || o.lat != 3 || o.err !== 1'b0) begin
            miscompares++; $display("FAIL sh_done: got ld=%h lat=%0d err=%b, want %h 3 0", o.ld, o.lat, o.err, exp_ld);
        end
    endtask

    task automatic test_errors;
        obs_t o;
        logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011};
        logic [31:0] as  [5] = '{32'h102, 32'h21, 32'h40, 32'h40, 32'h40};
        bit          rds [5] = '{1, 0, 1, 0, 1};
        bit          wrs [5] = '{0, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive_txn(rds[i], wrs[i], f3s[i], as[i], 32'h12345678, 32'hCAFEF00D, 0, o);
            vectors++;
            if (o.lat != 1 || o.err !== 1'b1 || o.req_cycles != 0 || o.ld !== exp_ld || o.busy_after !== 1'b0) begin
                miscompares++;
                $display("FAIL error_case%0d: got lat=%0d err=%b reqs=%0d ld=%h busy_after=%b, want 1 1 0 %h 0",
                         i, o.lat, o.err, o.req_cycles, o.ld, exp_ld, o.busy_after);
            end
        end
    endtask

    task automatic test_held_request;
        int reqs = 0, dones = 0;
        logic prev_req = 1'b0;
        dMemRead = 1; dMemWrite = 0; funct3 = 3'b010; addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.memAck = bus.memReq; bus.memRdata = 32'h0BADF00D;
            if (bus.memReq && !prev_req) reqs++;
            if (lsuDone) dones++;
            prev_req = bus.memReq;
        end
        exp_ld = 32'h0BADF00D;
        dMemRead = 0;
        @(negedge clk);
        bus.memAck = 1'b0;
        if (lsuDone) dones++;
        vectors++;
        if (reqs != 1 || dones != 1 || loadData !== exp_ld) begin
            miscompares++; $display("FAIL held_request: got reqs=%0d dones=%0d ld=%h, want 1 1 %h", reqs, dones, loadData, exp_ld);
        end
        dMemRead = 1; addr = 32'h44;
        @(negedge clk);
        dMemRead = 0;
        vectors++;
        if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h44) begin
            miscompares++; $display("FAIL rearm_accept: got req=%b addr=%h, want 1 44", bus.memReq, bus.memAddr);
        end
        bus.memAck = 1'b1; bus.memRdata = 32'h76543210;
        @(negedge clk);
        bus.memAck = 1'b0;
        exp_ld = 32'h76543210;
        vectors++;
        if (lsuDone !== 1'b1 || loadData !== exp_ld) begin
            miscompares++; $display("FAIL rearm_done: got done=%b ld=%h, want 1 %h", lsuDone, loadData, exp_ld);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req;
        int dones = 0;
        obs_t o;
        dMemRead = 1; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        dMemRead = 0;
        vectors++;
        if (bus.memReq !== 1'b1) begin
            miscompares++; $display("FAIL mid_req_pre: got req=%b, want 1", bus.memReq);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.memReq !== 1'b0 || lsuBusy !== 1'b0) begin
            miscompares++; $display("FAIL async_reset: got req=%b busy=%b, want 0 0", bus.memReq, lsuBusy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.memAck = 1'b1; bus.memRdata = 32'hFFFFFFFF;
        exp_ld = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.memAck = 1'b0;
            if (lsuDone) dones++;
        end
        vectors++;
        if (dones != 0 || {loadData, lsuBusy, accessErr, bus.memReq, bus.memWe, bus.memAddr, bus.memBe, bus.memWdata} !== '0) begin
            miscompares++;
            $display("FAIL late_ack: got dones=%0d ld=%h busy=%b req=%b, want 0 and all outputs 0", dones, loadData, lsuBusy, bus.memReq);
        end
        drive_txn(1, 0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 1, o);
        exp_ld = 32'h13579BDF;
        vectors++;
        if (o.lat != 3 || o.ld !== exp_ld || o.maddr !== 32'h300) begin
            miscompares++; $display("FAIL post_reset_lw: got lat=%0d ld=%h addr=%h, want 3 %h 300", o.lat, o.ld, o.maddr, exp_ld);
        end
    endtask

    task automatic test_random;
        obs_t o;
        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 7);
            bit rd = (op != 1 && op != 2 && op != 3) || op == 7;
            bit wr = (op >= 1 && op <= 3) || op == 7;
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] sd = $urandom;
            logic [31:0] rdata = $urandom;
            int waits = $urandom_range(0, 3);
            bit e = m_err(rd, wr, f3, a);
            if (!e && !wr) exp_ld = m_ld(f3, a, rdata);
            drive_txn(rd, wr, f3, a, sd, rdata, waits, o);
            vectors++;
            if (o.err !== e || o.lat != (e ? 1 : waits + 2) || o.req_cycles != (e ? 0 : waits + 1) ||
                o.ld !== exp_ld || !o.stable || o.busy_after !== 1'b0 || o.req_after !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_ctrl: rd=%b wr=%b f3=%b a=%h got err=%b lat=%0d reqs=%0d ld=%h, want %b %0d %0d %h",
                         i, rd, wr, f3, a, o.err, o.lat, o.req_cycles, o.ld, e, e ? 1 : waits + 2, e ? 0 : waits + 1, exp_ld);
            end
            if (!e) begin
                vectors++;
                if (o.maddr !== {a[31:2], 2'b00} || o.be !== m_be(f3, a) || o.we !== wr || (wr && o.wd !== m_wd(f3, sd))) begin
                    miscompares++;
                    $display("FAIL rand%0d_bus: f3=%b a=%h got addr=%h be=%b we=%b wd=%h, want %h %b %b %h",
                             i, f3, a, o.maddr, o.be, o.we, o.wd, {a[31:2], 2'b00}, m_be(f3, a), wr, m_wd(f3, sd));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        dMemRead = 0; dMemWrite = 0; funct3 = '0; addr = '0; storeData = '0;
        bus.memAck = 1'b0; bus.memRdata = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_lw_waits;
        test_lb_lbu;
        test_sh;
        test_errors;
        test_held_request;
        test_reset_mid_req;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
